// File: rtl/minilab_0_pkg.sv
// ============================================================================
// Module : minilab_0_pkg
// Brief  : Shared types, sizing constants and 7-segment decoder for minilab_0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package minilab_0_pkg;

    localparam int DEPTH      = 8;
    localparam int DATA_WIDTH = 8;
    localparam int ACC_WIDTH  = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } state_t;

    // Active-low gfedcba segment pattern for one hex digit.
    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/minilab_0_fifo.sv
// ============================================================================
// Module : minilab_0_fifo
// Brief  : Synchronous FIFO with registered read data; async active-low reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module minilab_0_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_rd_data;
    logic             w_do_wr;
    logic             w_do_rd;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_wr   = i_wr_en && !o_full;
    assign w_do_rd   = i_rd_en && !o_empty;
    assign o_rd_data = r_rd_data;

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Read data only changes on a successful pop, so an empty read holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_rd) begin
                r_rd_ptr  <= next_ptr(r_rd_ptr);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/minilab_0.sv
// ============================================================================
// Module : minilab_0
// Brief  : Fill two FIFOs with 1..DEPTH, then accumulate their dot product and
//          show it on HEX5..HEX0. Optional macro: DISPLAY_GATE_EN (SW[0] gate).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module minilab_0
    import minilab_0_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       CLOCK2_50,
    input  logic       CLOCK3_50,
    input  logic       CLOCK4_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int DIGITS = ACC_WIDTH / 4;

    logic                  clk;
    logic                  rst_n;
    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_fill_cnt;
    logic [CNT_W-1:0]      r_exec_cnt;
    logic                  r_pop_valid;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_fill_data;
    logic [DATA_WIDTH-1:0] w_a_data;
    logic [DATA_WIDTH-1:0] w_b_data;
    logic                  w_a_full;
    logic                  w_b_full;
    logic                  w_a_empty;
    logic                  w_b_empty;
    logic [PROD_W-1:0]     w_prod;
    logic [6:0]            w_hex [DIGITS];
    logic                  w_unused;

    assign clk   = CLOCK_50;
    assign rst_n = KEY[0];

`ifdef DISPLAY_GATE_EN
    assign w_unused = &{1'b0, KEY[3:1], CLOCK2_50, CLOCK3_50, CLOCK4_50, SW[9:1]};
`else
    assign w_unused = &{1'b0, KEY[3:1], CLOCK2_50, CLOCK3_50, CLOCK4_50, SW};
`endif

    assign w_fill_data = DATA_WIDTH'(r_fill_cnt) + DATA_WIDTH'(1);

    minilab_0_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_WIDTH)) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_fill_data),
        .i_rd_en   (w_rd_en),
        .o_rd_data (w_a_data),
        .o_full    (w_a_full),
        .o_empty   (w_a_empty)
    );

    minilab_0_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_WIDTH)) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_fill_data),
        .i_rd_en   (w_rd_en),
        .o_rd_data (w_b_data),
        .o_full    (w_b_full),
        .o_empty   (w_b_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // EXEC stays one cycle past the last pop so the final product lands.
    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        w_rd_en      = 1'b0;
        case (r_state)
            IDLE: w_state_next = FILL;
            FILL: begin
                w_wr_en = !w_a_full && !w_b_full;
                if (w_wr_en && (r_fill_cnt == CNT_W'(DEPTH - 1))) begin
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                w_rd_en = !w_a_empty && !w_b_empty;
                if (r_exec_cnt == CNT_W'(DEPTH)) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = DONE;
        endcase
    end

    assign w_prod = {{DATA_WIDTH{1'b0}}, w_a_data} * {{DATA_WIDTH{1'b0}}, w_b_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_cnt  <= '0;
            r_exec_cnt  <= '0;
            r_pop_valid <= 1'b0;
            r_acc       <= '0;
        end else begin
            if (w_wr_en) begin
                r_fill_cnt <= r_fill_cnt + CNT_W'(1);
            end
            if ((r_state == EXEC) && (r_exec_cnt != CNT_W'(DEPTH))) begin
                r_exec_cnt <= r_exec_cnt + CNT_W'(1);
            end
            r_pop_valid <= w_rd_en;
            if (r_pop_valid) begin
                r_acc <= r_acc + {{(ACC_WIDTH - PROD_W){1'b0}}, w_prod};
            end
        end
    end

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_hex
`ifdef DISPLAY_GATE_EN
            assign w_hex[g] = SW[0] ? hex7seg(r_acc[4*g +: 4]) : 7'h7F;
`else
            assign w_hex[g] = hex7seg(r_acc[4*g +: 4]);
`endif
        end
    endgenerate

    assign HEX0 = w_hex[0];
    assign HEX1 = w_hex[1];
    assign HEX2 = w_hex[2];
    assign HEX3 = w_hex[3];
    assign HEX4 = w_hex[4];
    assign HEX5 = w_hex[5];
    assign LEDR = {8'd0, r_state};

endmodule

`default_nettype wire

// File: tb/tb_minilab_0.sv
// ============================================================================
// Module : tb_minilab_0
// Brief  : Randomized self-checking bench for minilab_0 against a timeline model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_minilab_0;

    logic       CLOCK_50  = 1'b0;
    logic       CLOCK2_50 = 1'b0;
    logic       CLOCK3_50 = 1'b0;
    logic       CLOCK4_50 = 1'b0;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    always #10 CLOCK_50 = ~CLOCK_50;
    always #7  CLOCK2_50 = ~CLOCK2_50;

    minilab_0 dut (
        .CLOCK_50  (CLOCK_50),
        .CLOCK2_50 (CLOCK2_50),
        .CLOCK3_50 (CLOCK3_50),
        .CLOCK4_50 (CLOCK4_50),
        .KEY       (KEY),
        .SW        (SW),
        .LEDR      (LEDR),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3),
        .HEX4      (HEX4),
        .HEX5      (HEX5)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // t = rising edges since reset release.
    function automatic logic [1:0] exp_state(input int t);
        if (t <= 0)  return 2'd0;
        if (t <= 8)  return 2'd1;
        if (t <= 17) return 2'd2;
        return 2'd3;
    endfunction

    // Product k*k lands on edge 10+k; result is the partial sum of squares.
    function automatic logic [23:0] exp_acc(input int t);
        int unsigned s = 0;
        int n = t - 10;
        if (n > 8) n = 8;
        for (int k = 1; k <= n; k++) s += k * k;
        return s[23:0];
    endfunction

    function automatic logic [41:0] exp_hex(input logic [23:0] acc, input logic sw0);
        logic [41:0] r;
        for (int d = 0; d < 6; d++) begin
`ifdef DISPLAY_GATE_EN
            r[7*d +: 7] = sw0 ? SEG[acc[4*d +: 4]] : 7'h7F;
`else
            r[7*d +: 7] = SEG[acc[4*d +: 4]];
`endif
        end
        return r;
    endfunction

    function automatic logic [41:0] hex_bus();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    task automatic sample(input string tag, input int t);
        SW       = 10'($urandom);
        KEY[3:1] = 3'($urandom);
        #1;
        check({tag, "_ledr"}, 64'(LEDR), {54'd0, 8'd0, exp_state(t)});
        check({tag, "_hex"},  64'(hex_bus()), 64'(exp_hex(exp_acc(t), SW[0])));
    endtask

    // Releases reset on a negedge and follows the timeline through edge stop_t.
    task automatic run_to(input int stop_t);
        @(negedge CLOCK_50);
        KEY[0] = 1'b1;
        sample("t0", 0);
        for (int t = 1; t <= stop_t; t++) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            sample("run", t);
        end
    endtask

    task automatic hold_reset(input int cycles);
        KEY[0] = 1'b0;
        repeat (cycles) @(negedge CLOCK_50);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int abort_t;
        KEY = {3'($urandom), 1'b0};
        SW  = 10'($urandom);
        #20;
        @(negedge CLOCK_50);
        sample("reset", 0);
        SW[0] = 1'b1;
        #1;
        check("reset_hex_on", 64'(hex_bus()), 64'(exp_hex(24'd0, 1'b1)));

        run_to(20);
        SW[0] = 1'b1;
        #1;
        check("done_acc", 64'(hex_bus()), 64'(exp_hex(24'h0000CC, 1'b1)));

        for (int i = 0; i < 100; i++) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            sample("hold", 100);
        end

`ifdef DISPLAY_GATE_EN
        SW[0] = 1'b0;
        #1;
        check("gate_off", 64'(hex_bus()), 64'({6{7'h7F}}));
        SW[0] = 1'b1;
        #1;
        check("gate_on", 64'(hex_bus()), 64'({{4{7'b1000000}}, {2{7'b1000110}}}));
`endif

        for (int it = 0; it < 6; it++) begin
            hold_reset(2);
            abort_t = (it == 0) ? int'($urandom_range(10, 17)) : int'($urandom_range(1, 17));
            run_to(abort_t);
            #($urandom_range(1, 7));
            KEY[0] = 1'b0;
            #1;
            check("abort_ledr", 64'(LEDR), 64'd0);
            check("abort_hex", 64'(hex_bus()), 64'(exp_hex(24'd0, SW[0])));
        end

        hold_reset(3);
        run_to(22);
        SW[0] = 1'b1;
        #1;
        check("rerun_ledr", 64'(LEDR), 64'd3);
        check("rerun_acc", 64'(hex_bus()), 64'(exp_hex(24'h0000CC, 1'b1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
